// File: rtl/rs232_rx_fifo.sv
// RS-232 receive FIFO: drains the receiver through a done handshake into a
// first-word-fall-through buffer read by the CPU. Dropped bytes raise a sticky overrun.
module rs232_rx_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic                       rx_rdy,
  input  logic [7:0]                 rx_data,
  output logic                       rx_done,
  input  logic                       pop,
  input  logic                       clr_ovr,
  output logic [7:0]                 dout,
  output logic                       nonempty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overrun
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACK  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  logic [7:0]    mem [DEPTH];
  logic [1:0]    state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovr_q, ovr_d;
  logic          done_q, done_d;
  logic          push, drop, pop_ok, full;

  assign full     = (count_q == FULL_CNT);
  assign nonempty = (count_q != '0);
  assign dout     = nonempty ? mem[rd_ptr_q] : 8'h00;
  assign count    = count_q;
  assign overrun  = ovr_q;
  assign rx_done  = done_q;

  always_comb begin
    state_d  = state_q;
    done_d   = done_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovr_d    = ovr_q;
    push     = 1'b0;
    drop     = 1'b0;
    pop_ok   = 1'b0;
    if (enable) begin
      pop_ok = pop && nonempty;
      done_d = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (rx_rdy) begin
            state_d = ST_ACK;
            done_d  = 1'b1;
            // A full FIFO still accepts the byte when the CPU frees a slot this cycle.
            if (!full || pop_ok) push = 1'b1;
            else                 drop = 1'b1;
          end
        end
        ST_ACK:  state_d = ST_WAIT;
        ST_WAIT: if (!rx_rdy) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
      if (push)   wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok) rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop_ok)      count_d = count_q + (AW+1)'(1);
      else if (pop_ok && !push) count_d = count_q - (AW+1)'(1);
      if (drop)         ovr_d = 1'b1;
      else if (clr_ovr) ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      done_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      done_q   <= done_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovr_q    <= ovr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr_q] <= rx_data;
  end

endmodule

// File: tb/tb_rs232_rx_fifo.sv
// Directed bench for rs232_rx_fifo: handshake, FWFT ordering, overrun, wrap, reset, enable.
module tb_rs232_rx_fifo;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       rx_rdy;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       pop;
  logic       clr_ovr;
  logic [7:0] dout;
  logic       nonempty;
  logic [4:0] count;
  logic       overrun;

  int checks = 0;
  int errors = 0;

  rs232_rx_fifo #(.DEPTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .rx_rdy   (rx_rdy),
    .rx_data  (rx_data),
    .rx_done  (rx_done),
    .pop      (pop),
    .clr_ovr  (clr_ovr),
    .dout     (dout),
    .nonempty (nonempty),
    .count    (count),
    .overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Receiver presents a byte for two enabled cycles, then releases rdy.
  task automatic push_byte(input logic [7:0] b);
    rx_data = b;
    rx_rdy  = 1'b1;
    step();
    chk("push_done_hi", rx_done, 1);
    step();
    chk("push_done_lo", rx_done, 0);
    rx_rdy = 1'b0;
    step();
  endtask

  task automatic pop_byte(input logic [7:0] exp);
    chk("pop_dout", dout, exp);
    pop = 1'b1;
    step();
    pop = 1'b0;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; rx_rdy = 1'b0; rx_data = 8'h00; pop = 1'b0; clr_ovr = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("rst_count", count, 0);
    chk("rst_nonempty", nonempty, 0);
    chk("rst_dout", dout, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_done", rx_done, 0);

    // Single byte held for two enabled cycles: exactly one write.
    rx_data = 8'h41; rx_rdy = 1'b1;
    step();
    chk("b41_done", rx_done, 1);
    chk("b41_count", count, 1);
    chk("b41_dout", dout, 8'h41);
    chk("b41_nonempty", nonempty, 1);
    step();
    chk("b41_done2", rx_done, 0);
    chk("b41_count2", count, 1);
    rx_rdy = 1'b0;
    step();
    chk("b41_count3", count, 1);
    pop_byte(8'h41);
    chk("b41_empty", count, 0);

    // Fill to 16.
    for (int i = 1; i <= 16; i++) push_byte(8'(i));
    chk("full_count", count, 16);

    // Push while full: dropped, overrun set, handshake still completes.
    push_byte(8'hAA);
    chk("ovr_set", overrun, 1);
    chk("ovr_count", count, 16);
    chk("ovr_head", dout, 8'h01);
    clr_ovr = 1'b1;
    step();
    clr_ovr = 1'b0;
    chk("ovr_clr", overrun, 0);

    // Drop and clear in the same cycle: set wins.
    rx_data = 8'hAB; rx_rdy = 1'b1; clr_ovr = 1'b1;
    step();
    clr_ovr = 1'b0;
    chk("ovr_set_wins", overrun, 1);
    step();
    rx_rdy = 1'b0;
    step();
    clr_ovr = 1'b1;
    step();
    clr_ovr = 1'b0;
    chk("ovr_clr2", overrun, 0);

    // Drain in order, count stepping down.
    for (int i = 1; i <= 16; i++) begin
      chk("drain_count", count, 17 - i);
      pop_byte(8'(i));
    end
    chk("drain_count0", count, 0);
    chk("drain_nonempty", nonempty, 0);
    chk("drain_dout", dout, 0);

    // Refill, then push 0x55 and pop in the same cycle while full.
    for (int i = 1; i <= 16; i++) push_byte(8'(i));
    chk("refill_count", count, 16);
    rx_data = 8'h55; rx_rdy = 1'b1; pop = 1'b1;
    chk("pp_head", dout, 8'h01);
    step();
    pop = 1'b0;
    chk("pp_count", count, 16);
    chk("pp_ovr", overrun, 0);
    chk("pp_newhead", dout, 8'h02);
    step();
    rx_rdy = 1'b0;
    step();
    for (int i = 2; i <= 16; i++) pop_byte(8'(i));
    pop_byte(8'h55);
    chk("pp_empty", count, 0);

    // Pop on empty is ignored; next byte lands at the head.
    pop = 1'b1;
    step();
    pop = 1'b0;
    chk("uf_count", count, 0);
    chk("uf_nonempty", nonempty, 0);
    push_byte(8'h77);
    chk("uf_count1", count, 1);
    chk("uf_dout", dout, 8'h77);
    pop_byte(8'h77);

    // 40 bytes interleaved with pops, wrapping the pointers.
    for (int i = 0; i < 40; i++) begin
      push_byte(8'h80 + 8'(i));
      if (i >= 2) begin
        chk("wrap_count", count, 3);
        pop_byte(8'h80 + 8'(i - 2));
      end
    end
    pop_byte(8'h80 + 8'd38);
    pop_byte(8'h80 + 8'd39);
    chk("wrap_empty", count, 0);
    chk("wrap_ovr", overrun, 0);

    // Reset while in WAIT with five bytes stored.
    for (int i = 0; i < 4; i++) push_byte(8'hC0 + 8'(i));
    rx_data = 8'hC4; rx_rdy = 1'b1;
    step();
    step();
    chk("wait_count", count, 5);
    chk("wait_done", rx_done, 0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("wrst_count", count, 0);
    chk("wrst_done", rx_done, 0);
    chk("wrst_ovr", overrun, 0);
    chk("wrst_nonempty", nonempty, 0);

    // Enable low: rdy held high, pop requested, nothing moves.
    enable = 1'b0; rx_data = 8'h3C; pop = 1'b1;
    for (int i = 0; i < 10; i++) step();
    pop = 1'b0;
    chk("en0_count", count, 0);
    chk("en0_done", rx_done, 0);
    enable = 1'b1;
    step();
    chk("en1_capture", count, 1);
    chk("en1_dout", dout, 8'h3C);
    chk("en1_done", rx_done, 1);
    enable = 1'b0; pop = 1'b1;
    step();
    step();
    pop = 1'b0;
    chk("en0_done_hold", rx_done, 1);
    chk("en0_no_pop", count, 1);
    enable = 1'b1;
    step();
    chk("en1_done_lo", rx_done, 0);
    rx_rdy = 1'b0;
    step();
    chk("final_count", count, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rs232_rx_fifo.md
Name: rs232_rx_fifo

Overview:
- Receive buffer between the RS-232 receiver (RS232R) and the CPU I/O bus.
- Drains each byte from the receiver with a done handshake and stores it in a first-word-fall-through FIFO.
- The CPU reads bytes from the FIFO instead of the receiver's single data register, so bytes are no longer lost while the CPU is busy (e.g. during video stalls or disk I/O).
- Reports fill level and a sticky overrun flag for the RS-232 status word.

Parameters:
- DEPTH, 16, number of byte entries; power of two, 4..256.
- AW, log2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  input  1  system clock; same clock as the CPU.
- rst  input  1  synchronous reset, active-high.
- enable  input  1  clock enable; all state advances only on clk edges with enable=1.
- rx_rdy  input  1  receiver holds a valid byte.
- rx_data  input  8  receiver byte.
- rx_done  output  1  acknowledge to receiver; clears its rdy.
- pop  input  1  CPU read of the data register (rd & ioenb & data address).
- clr_ovr  input  1  CPU write to the status register; clears overrun.
- dout  output  8  byte at FIFO head; 0 when empty.
- nonempty  output  1  FIFO holds at least one byte.
- count  output  AW+1  number of stored bytes, 0..DEPTH.
- overrun  output  1  sticky: a byte was dropped because the FIFO was full.

Behaviour:
- Reset, synchronous on rst=1 at a clk edge, independent of enable:
  - wr_ptr=0, rd_ptr=0, count=0, overrun=0, rx_done=0, state=IDLE.
  - Memory contents are not cleared.
  - Reset asserted in any state abandons any handshake in progress; the receiver re-presents its byte afterwards.
- Intake FSM (advances only when enable=1):
  - IDLE: if rx_rdy=1, go to ACK.
    - If not full, or if pop=1 in the same cycle: write rx_data at wr_ptr and increment wr_ptr (mod DEPTH).
    - Otherwise: discard the byte and set overrun=1.
  - ACK: rx_done=1 (registered output, high for exactly one enabled cycle); go to WAIT.
  - WAIT: rx_done=0; stay until rx_rdy=0, then go to IDLE.
  - This blocks re-capture of the same byte while the receiver's rdy is still falling.
- Push-to-visible latency: a byte captured at edge N is on dout with nonempty=1 after edge N.
- Pop: on an enabled edge with pop=1 and nonempty=1, increment rd_ptr (mod DEPTH).
  - pop on an empty FIFO is ignored; count stays 0 and no underflow occurs.
  - The CPU reads dout combinationally in the same cycle, first-word fall-through.
- count:
  - +1 on push only, -1 on pop only, unchanged on push and pop together.
  - Never exceeds DEPTH and never wraps below 0.
- full = (count==DEPTH). Push while full is allowed only when a pop occurs in the same cycle.
- dout = mem[rd_ptr] when nonempty, else 8'h00.
- overrun:
  - Set on a dropped byte.
  - Cleared by clr_ovr=1 on an enabled edge.
  - Set wins over clear when both happen in the same cycle.
- Pointers wrap from DEPTH-1 to 0 with no gap.
- With enable=0: no state change, and rx_done holds its value.
- No combinational path from rx_rdy to rx_done.

Test Plan:
- Reset, then receiver presents 8'h41 with rx_rdy=1 for 2 enabled cycles -> exactly one write; rx_done high for one enabled cycle; count=1; dout=8'h41; nonempty=1.
- Push 8'h01..8'h10 (16 bytes), then pop 16 times -> dout sequence 8'h01..8'h10 in order; count steps 16..0; nonempty=0 and dout=0 at the end.
- With the FIFO full (16), push 8'hAA -> byte dropped; overrun=1; count=16; rx_done still pulses. Then clr_ovr=1 -> overrun=0.
- With the FIFO full, push 8'h55 and pop in the same enabled cycle -> count stays 16; the popped byte is the old head; 8'h55 is the last byte read out after 16 pops.
- Pop on empty FIFO -> count=0, rd_ptr unchanged. Then push 40 bytes interleaved with pops (count stays ≤3), exercising pointer wrap -> all 40 bytes read back in order with no overrun.
- Assert rst during WAIT with count=5 -> next edge: count=0, rx_done=0, overrun=0, state IDLE. With enable=0 held for 10 cycles and rx_rdy=1 -> no capture.
